i_decode: RTL and testbench
===========================

# i_decode

Instruction decode stage, directly downstream of instruction fetch. Registers the fetched instruction's decoded control word, sign-extended immediate, and register-file operands into the ID/EX pipeline register. Owns the 32-entry integer register file, which is written by the writeback stage. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
- DATA_WIDTH, 32: register and immediate width
- INSTR_WIDTH, 32: instruction width
- REG_COUNT, 32: architectural registers; x0 hardwired to zero
- PC_WIDTH, 5: program-counter width, matches fetch PC width
- REG_ADDR_WIDTH, $clog2(REG_COUNT): non-modifiable
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_IF_instr  in  INSTR_WIDTH  fetched instruction
- i_IF_program_cntr  in  PC_WIDTH  PC of i_IF_instr
- i_IF_program_cntr_next  in  PC_WIDTH  PC+4 of i_IF_instr
- i_stall  in  1  hold ID/EX register
- i_flush  in  1  load bubble into ID/EX register
- i_WB_reg_wr_en, i_WB_rd_addr, i_WB_rd_data  in  1 / REG_ADDR_WIDTH / DATA_WIDTH  writeback port
- o_ID_valid  out  1  ID/EX holds a real instruction
- o_ID_illegal  out  1  unsupported opcode
- o_ID_rs1_data, o_ID_rs2_data  out  DATA_WIDTH  operands
- o_ID_imm  out  DATA_WIDTH  sign-extended immediate
- o_ID_rs1_addr, o_ID_rs2_addr, o_ID_rd_addr  out  REG_ADDR_WIDTH  register indices, for forwarding
- o_ID_program_cntr, o_ID_program_cntr_next  out  PC_WIDTH  forwarded PCs
- o_ID_funct3  out  3  branch/load/store sub-op
- o_ID_alu_ctrl  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10
- o_ID_alu_a_sel  out  1  0=rs1, 1=PC
- o_ID_alu_b_sel  out  1  0=rs2, 1=imm
- o_ID_result_sel  out  2  0=ALU, 1=memory, 2=PC+4
- o_ID_reg_wr_en, o_ID_mem_rd_en, o_ID_mem_wr_en, o_ID_branch, o_ID_jump  out  1 each  control enables

## Operation
- The decode logic is combinational from i_IF_instr; all o_ID_* outputs are registers.
- Decoded opcodes:
  - R (0110011): alu_ctrl from funct3 and funct7[5]
  - I-ALU (0010011): SRAI when funct7[5]=1
  - LOAD (0000011), STORE (0100011), BRANCH (1100011)
  - JAL (1101111), JALR (1100111)
  - LUI (0110111): PASS_B
  - AUIPC (0010111): a_sel=1, ADD
- Immediate formats I/S/B/U/J per RV32I, sign-extended from bit 31. B and J immediates have bit0=0.
- An all-zero instruction is a bubble: valid=0, illegal=0, all enables 0.
- Any other undecoded opcode: valid=1, illegal=1, all enables 0.
- rd_addr is forced to 0 when reg_wr_en=0. reg_wr_en is 0 for STORE and BRANCH.
- Register file:
  - Write on rising edge when i_WB_reg_wr_en=1 and i_WB_rd_addr≠0.
  - Reads of x0 return 0.
  - All entries clear to 0 on reset.
- Priority per edge: reset > i_flush > i_stall > normal load.
  - Flush: valid=0 and all enables 0. Data fields are don't-care but are driven to 0.
  - Stall: every o_ID_* output holds its value.
- Register-file writes proceed regardless of stall or flush.

## Timing
- Latency is 1 cycle: an instruction present before edge N appears on the outputs after edge N.
- Reset (asynchronous assert, synchronous release at the next edge): every output is 0, and all registers are 0.
- A WB write at edge N is visible to any instruction sampled at edge N+1 or later.
- For a same-edge read/write collision, see Configuration.
- Under stall, operand data is not re-read. The hazard unit forwards any newer value.

## Configuration
- ID_WB_BYPASS_EN defined: when i_WB_reg_wr_en=1, i_WB_rd_addr≠0 and i_WB_rd_addr equals rs1 or rs2 of the instruction being loaded, the ID/EX register captures i_WB_rd_data at that edge (write-first).
- ID_WB_BYPASS_EN undefined: the ID/EX register captures the pre-write register-file value. Downstream forwarding must cover this case.

## Test plan
- Reset release with i_IF_instr=0 → all outputs 0 and o_ID_valid=0 for every cycle.
- WB writes x1=5, then 0x00008133 (add x2,x1,x0) → rs1_data=5, rs2_data=0, rd_addr=2, alu_ctrl=0, reg_wr_en=1, valid=1.
- 0xFFF08193 (addi x3,x1,-1) → imm=0xFFFFFFFF, b_sel=1, rd_addr=3.
- WB writes x0=0xDEAD → a subsequent read of x0 returns 0.
- Same-edge WB write x1=7 while loading add x2,x1,x0 → rs1_data=7 with ID_WB_BYPASS_EN defined, 5 without it.
- Stall for 2 cycles then flush → outputs hold for 2 cycles, then valid=0 and all enables 0.
- 0xFFFFFFFF → illegal=1, valid=1, all enables 0.
- Async reset asserted mid-stream → outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/i_decode.sv
// Instruction decode stage: decodes the fetched instruction into a control
// word and sign-extended immediate, reads operands from the 32-entry integer
// register file, and registers everything into the ID/EX pipeline register.
// Stall holds the ID/EX register; flush loads a bubble (all fields zero).
// Optional feature macro: ID_WB_BYPASS_EN -- when defined, a writeback to a
// register being read on the same edge is captured write-first.
module i_decode #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int REG_COUNT   = 32,
  parameter int PC_WIDTH    = 5,
  localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [INSTR_WIDTH-1:0]    i_IF_instr,
  input  logic [PC_WIDTH-1:0]       i_IF_program_cntr,
  input  logic [PC_WIDTH-1:0]       i_IF_program_cntr_next,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_WB_reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_WB_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_WB_rd_data,
  output logic                      o_ID_valid,
  output logic                      o_ID_illegal,
  output logic [DATA_WIDTH-1:0]     o_ID_rs1_data,
  output logic [DATA_WIDTH-1:0]     o_ID_rs2_data,
  output logic [DATA_WIDTH-1:0]     o_ID_imm,
  output logic [REG_ADDR_WIDTH-1:0] o_ID_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_ID_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_ID_rd_addr,
  output logic [PC_WIDTH-1:0]       o_ID_program_cntr,
  output logic [PC_WIDTH-1:0]       o_ID_program_cntr_next,
  output logic [2:0]                o_ID_funct3,
  output logic [3:0]                o_ID_alu_ctrl,
  output logic                      o_ID_alu_a_sel,
  output logic                      o_ID_alu_b_sel,
  output logic [1:0]                o_ID_result_sel,
  output logic                      o_ID_reg_wr_en,
  output logic                      o_ID_mem_rd_en,
  output logic                      o_ID_mem_wr_en,
  output logic                      o_ID_branch,
  output logic                      o_ID_jump
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  // One ID/EX pipeline record; flush simply loads '0.
  typedef struct packed {
    logic                      valid;
    logic                      illegal;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [PC_WIDTH-1:0]       pc;
    logic [PC_WIDTH-1:0]       pc_next;
    logic [2:0]                funct3;
    logic [3:0]                alu_ctrl;
    logic                      alu_a_sel;
    logic                      alu_b_sel;
    logic [1:0]                result_sel;
    logic                      reg_wr_en;
    logic                      mem_rd_en;
    logic                      mem_wr_en;
    logic                      branch;
    logic                      jump;
  } id_ex_t;

  logic [31:0]               ins;
  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic                      f7b5;
  logic [REG_ADDR_WIDTH-1:0] rs1_a;
  logic [REG_ADDR_WIDTH-1:0] rs2_a;
  logic [REG_ADDR_WIDTH-1:0] rd_a;
  logic [31:0]               imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]                alu_from_f3;
  logic [DATA_WIDTH-1:0]     rs1_rd, rs2_rd;
  logic [DATA_WIDTH-1:0]     rf_q [REG_COUNT];
  id_ex_t                    id_ex_d, id_ex_q;

  assign ins    = i_IF_instr[31:0];
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign f7b5   = ins[30];
  assign rs1_a  = REG_ADDR_WIDTH'(ins[19:15]);
  assign rs2_a  = REG_ADDR_WIDTH'(ins[24:20]);
  assign rd_a   = REG_ADDR_WIDTH'(ins[11:7]);

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // ALU operation shared by R and I-ALU forms; SUB is only legal for R.
  always_comb begin
    alu_from_f3 = ALU_ADD;
    unique case (funct3)
      3'b000: alu_from_f3 = (opcode == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_from_f3 = ALU_SLL;
      3'b010: alu_from_f3 = ALU_SLT;
      3'b011: alu_from_f3 = ALU_SLTU;
      3'b100: alu_from_f3 = ALU_XOR;
      3'b101: alu_from_f3 = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  end

  // Operand read; x0 is hardwired to zero.
  always_comb begin
    rs1_rd = (rs1_a == '0) ? '0 : rf_q[rs1_a];
    rs2_rd = (rs2_a == '0) ? '0 : rf_q[rs2_a];
`ifdef ID_WB_BYPASS_EN
    if (i_WB_reg_wr_en && i_WB_rd_addr != '0 && i_WB_rd_addr == rs1_a) rs1_rd = i_WB_rd_data;
    if (i_WB_reg_wr_en && i_WB_rd_addr != '0 && i_WB_rd_addr == rs2_a) rs2_rd = i_WB_rd_data;
`endif
  end

  // Decode the fetched instruction into the next ID/EX record.
  always_comb begin
    id_ex_d          = '0;
    id_ex_d.valid    = (ins != 32'h0);
    id_ex_d.rs1_data = rs1_rd;
    id_ex_d.rs2_data = rs2_rd;
    id_ex_d.rs1_addr = rs1_a;
    id_ex_d.rs2_addr = rs2_a;
    id_ex_d.pc       = i_IF_program_cntr;
    id_ex_d.pc_next  = i_IF_program_cntr_next;
    id_ex_d.funct3   = funct3;
    unique case (opcode)
      OP_R: begin
        id_ex_d.alu_ctrl  = alu_from_f3;
        id_ex_d.reg_wr_en = 1'b1;
      end
      OP_I: begin
        id_ex_d.alu_ctrl  = alu_from_f3;
        id_ex_d.alu_b_sel = 1'b1;
        id_ex_d.imm       = DATA_WIDTH'($signed(imm_i));
        id_ex_d.reg_wr_en = 1'b1;
      end
      OP_LOAD: begin
        id_ex_d.alu_b_sel  = 1'b1;
        id_ex_d.imm        = DATA_WIDTH'($signed(imm_i));
        id_ex_d.result_sel = 2'd1;
        id_ex_d.reg_wr_en  = 1'b1;
        id_ex_d.mem_rd_en  = 1'b1;
      end
      OP_STORE: begin
        id_ex_d.alu_b_sel = 1'b1;
        id_ex_d.imm       = DATA_WIDTH'($signed(imm_s));
        id_ex_d.mem_wr_en = 1'b1;
      end
      OP_BRANCH: begin
        // Branch compare runs through the ALU as rs1 - rs2.
        id_ex_d.alu_ctrl = ALU_SUB;
        id_ex_d.imm      = DATA_WIDTH'($signed(imm_b));
        id_ex_d.branch   = 1'b1;
      end
      OP_JAL: begin
        id_ex_d.alu_a_sel  = 1'b1;
        id_ex_d.alu_b_sel  = 1'b1;
        id_ex_d.imm        = DATA_WIDTH'($signed(imm_j));
        id_ex_d.result_sel = 2'd2;
        id_ex_d.reg_wr_en  = 1'b1;
        id_ex_d.jump       = 1'b1;
      end
      OP_JALR: begin
        id_ex_d.alu_b_sel  = 1'b1;
        id_ex_d.imm        = DATA_WIDTH'($signed(imm_i));
        id_ex_d.result_sel = 2'd2;
        id_ex_d.reg_wr_en  = 1'b1;
        id_ex_d.jump       = 1'b1;
      end
      OP_LUI: begin
        id_ex_d.alu_ctrl  = ALU_PASS;
        id_ex_d.alu_b_sel = 1'b1;
        id_ex_d.imm       = DATA_WIDTH'($signed(imm_u));
        id_ex_d.reg_wr_en = 1'b1;
      end
      OP_AUIPC: begin
        id_ex_d.alu_a_sel = 1'b1;
        id_ex_d.alu_b_sel = 1'b1;
        id_ex_d.imm       = DATA_WIDTH'($signed(imm_u));
        id_ex_d.reg_wr_en = 1'b1;
      end
      default: id_ex_d.illegal = id_ex_d.valid;
    endcase
    // A non-writing instruction must never look like a producer to forwarding.
    id_ex_d.rd_addr = id_ex_d.reg_wr_en ? rd_a : '0;
  end

  // ID/EX register: flush beats stall, stall holds, otherwise load.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   id_ex_q <= '0;
    else if (i_flush) id_ex_q <= '0;
    else if (!i_stall) id_ex_q <= id_ex_d;
  end

  // Register file write port; independent of stall and flush.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (i_WB_reg_wr_en && i_WB_rd_addr != '0) begin
      rf_q[i_WB_rd_addr] <= i_WB_rd_data;
    end
  end

  assign o_ID_valid             = id_ex_q.valid;
  assign o_ID_illegal           = id_ex_q.illegal;
  assign o_ID_rs1_data          = id_ex_q.rs1_data;
  assign o_ID_rs2_data          = id_ex_q.rs2_data;
  assign o_ID_imm               = id_ex_q.imm;
  assign o_ID_rs1_addr          = id_ex_q.rs1_addr;
  assign o_ID_rs2_addr          = id_ex_q.rs2_addr;
  assign o_ID_rd_addr           = id_ex_q.rd_addr;
  assign o_ID_program_cntr      = id_ex_q.pc;
  assign o_ID_program_cntr_next = id_ex_q.pc_next;
  assign o_ID_funct3            = id_ex_q.funct3;
  assign o_ID_alu_ctrl          = id_ex_q.alu_ctrl;
  assign o_ID_alu_a_sel         = id_ex_q.alu_a_sel;
  assign o_ID_alu_b_sel         = id_ex_q.alu_b_sel;
  assign o_ID_result_sel        = id_ex_q.result_sel;
  assign o_ID_reg_wr_en         = id_ex_q.reg_wr_en;
  assign o_ID_mem_rd_en         = id_ex_q.mem_rd_en;
  assign o_ID_mem_wr_en         = id_ex_q.mem_wr_en;
  assign o_ID_branch            = id_ex_q.branch;
  assign o_ID_jump              = id_ex_q.jump;

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: table of hand-encoded RV32I vectors, generated R/I
// sweeps against a small register-file model, and hand-written sequences for
// writeback collision, stall/flush and asynchronous reset.
module tb_i_decode;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [3:0]  alu;
    logic        a_sel;
    logic        b_sel;
    logic [1:0]  res;
    logic        wr;
    logic        mrd;
    logic        mwr;
    logic        br;
    logic        jmp;
    logic [4:0]  rd;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [4:0]  pc;
    logic [4:0]  pcn;
  } out_t;

  localparam int OW = $bits(out_t);

  typedef struct {
    string       name;
    logic [31:0] instr;
    out_t        exp;
  } vec_t;

  logic        i_clk;
  logic        i_reset_n;
  logic [31:0] i_IF_instr;
  logic [4:0]  i_IF_program_cntr;
  logic [4:0]  i_IF_program_cntr_next;
  logic        i_stall;
  logic        i_flush;
  logic        i_WB_reg_wr_en;
  logic [4:0]  i_WB_rd_addr;
  logic [31:0] i_WB_rd_data;
  logic        o_ID_valid;
  logic        o_ID_illegal;
  logic [31:0] o_ID_rs1_data;
  logic [31:0] o_ID_rs2_data;
  logic [31:0] o_ID_imm;
  logic [4:0]  o_ID_rs1_addr;
  logic [4:0]  o_ID_rs2_addr;
  logic [4:0]  o_ID_rd_addr;
  logic [4:0]  o_ID_program_cntr;
  logic [4:0]  o_ID_program_cntr_next;
  logic [2:0]  o_ID_funct3;
  logic [3:0]  o_ID_alu_ctrl;
  logic        o_ID_alu_a_sel;
  logic        o_ID_alu_b_sel;
  logic [1:0]  o_ID_result_sel;
  logic        o_ID_reg_wr_en;
  logic        o_ID_mem_rd_en;
  logic        o_ID_mem_wr_en;
  logic        o_ID_branch;
  logic        o_ID_jump;

  logic [OW-1:0] exp_q[$];
  logic [31:0]   rf_model [32];
  vec_t          vecs[$];
  int            n_checks;
  int            n_pass;

  i_decode dut (
    .i_clk                  (i_clk),
    .i_reset_n              (i_reset_n),
    .i_IF_instr             (i_IF_instr),
    .i_IF_program_cntr      (i_IF_program_cntr),
    .i_IF_program_cntr_next (i_IF_program_cntr_next),
    .i_stall                (i_stall),
    .i_flush                (i_flush),
    .i_WB_reg_wr_en         (i_WB_reg_wr_en),
    .i_WB_rd_addr           (i_WB_rd_addr),
    .i_WB_rd_data           (i_WB_rd_data),
    .o_ID_valid             (o_ID_valid),
    .o_ID_illegal           (o_ID_illegal),
    .o_ID_rs1_data          (o_ID_rs1_data),
    .o_ID_rs2_data          (o_ID_rs2_data),
    .o_ID_imm               (o_ID_imm),
    .o_ID_rs1_addr          (o_ID_rs1_addr),
    .o_ID_rs2_addr          (o_ID_rs2_addr),
    .o_ID_rd_addr           (o_ID_rd_addr),
    .o_ID_program_cntr      (o_ID_program_cntr),
    .o_ID_program_cntr_next (o_ID_program_cntr_next),
    .o_ID_funct3            (o_ID_funct3),
    .o_ID_alu_ctrl          (o_ID_alu_ctrl),
    .o_ID_alu_a_sel         (o_ID_alu_a_sel),
    .o_ID_alu_b_sel         (o_ID_alu_b_sel),
    .o_ID_result_sel        (o_ID_result_sel),
    .o_ID_reg_wr_en         (o_ID_reg_wr_en),
    .o_ID_mem_rd_en         (o_ID_mem_rd_en),
    .o_ID_mem_wr_en         (o_ID_mem_wr_en),
    .o_ID_branch            (o_ID_branch),
    .o_ID_jump              (o_ID_jump)
  );

  // Clock and reset-independent clock generation.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic out_t mk(logic v, logic il, logic [3:0] alu, logic a, logic b,
                              logic [1:0] res, logic wr, logic mrd, logic mwr, logic br,
                              logic jmp, logic [4:0] rd, logic [4:0] rs1a, logic [4:0] rs2a,
                              logic [2:0] f3, logic [31:0] imm, logic [31:0] rs1d,
                              logic [31:0] rs2d);
    out_t o;
    o = '0;
    o.valid = v; o.illegal = il; o.alu = alu; o.a_sel = a; o.b_sel = b; o.res = res;
    o.wr = wr; o.mrd = mrd; o.mwr = mwr; o.br = br; o.jmp = jmp; o.rd = rd;
    o.rs1a = rs1a; o.rs2a = rs2a; o.f3 = f3; o.imm = imm; o.rs1d = rs1d; o.rs2d = rs2d;
    return o;
  endfunction

  function automatic out_t actual();
    out_t o;
    o.valid = o_ID_valid; o.illegal = o_ID_illegal; o.alu = o_ID_alu_ctrl;
    o.a_sel = o_ID_alu_a_sel; o.b_sel = o_ID_alu_b_sel; o.res = o_ID_result_sel;
    o.wr = o_ID_reg_wr_en; o.mrd = o_ID_mem_rd_en; o.mwr = o_ID_mem_wr_en;
    o.br = o_ID_branch; o.jmp = o_ID_jump; o.rd = o_ID_rd_addr;
    o.rs1a = o_ID_rs1_addr; o.rs2a = o_ID_rs2_addr; o.f3 = o_ID_funct3;
    o.imm = o_ID_imm; o.rs1d = o_ID_rs1_data; o.rs2d = o_ID_rs2_data;
    o.pc = o_ID_program_cntr; o.pcn = o_ID_program_cntr_next;
    return o;
  endfunction

  task automatic add_vec(string n, logic [31:0] ins, out_t e);
    vec_t v;
    v.name = n; v.instr = ins; v.exp = e;
    vecs.push_back(v);
  endtask

  // Scoreboard pop and compare against the current DUT outputs.
  task automatic check_out(string name);
    out_t e, a;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = out_t'(exp_q.pop_front());
      a = actual();
      if (a !== e) $display("FAIL %s: got %h expected %h", name, a, e);
      else n_pass++;
    end
  endtask

  task automatic step(string name, out_t e);
    exp_q.push_back(OW'(e));
    @(posedge i_clk);
    #1;
    check_out(name);
  endtask

  task automatic run_instr(string n, logic [31:0] ins, logic [4:0] pc, out_t e);
    i_IF_instr = ins;
    i_IF_program_cntr = pc;
    i_IF_program_cntr_next = pc + 5'd4;
    e.pc = pc;
    e.pcn = pc + 5'd4;
    step(n, e);
  endtask

  task automatic wb_write(logic [4:0] addr, logic [31:0] data);
    i_WB_reg_wr_en = 1'b1;
    i_WB_rd_addr = addr;
    i_WB_rd_data = data;
    run_instr("wb_bubble", 32'h0, 5'd0, '0);
    i_WB_reg_wr_en = 1'b0;
    if (addr != 5'd0) rf_model[addr] = data;
  endtask

  initial begin
    logic [3:0]  alu_tab [8];
    logic [11:0] imm12;
    logic [4:0]  rd, pc;
    out_t        e, held;
    n_checks = 0;
    n_pass = 0;
    alu_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    for (int i = 0; i < 32; i++) rf_model[i] = '0;

    i_reset_n = 1'b0;
    i_IF_instr = '0; i_IF_program_cntr = '0; i_IF_program_cntr_next = '0;
    i_stall = 1'b0; i_flush = 1'b0;
    i_WB_reg_wr_en = 1'b0; i_WB_rd_addr = '0; i_WB_rd_data = '0;

    // Reset: outputs zero before any edge, while held, and after release with bubbles.
    exp_q.push_back('0);
    #1 check_out("reset_async_t0");
    step("reset_hold", '0);
    i_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) run_instr("reset_release", 32'h0, 5'd0, '0);

    wb_write(5'd1, 32'd5);
    wb_write(5'd5, 32'h8000_0000);
    wb_write(5'd6, 32'd3);
    wb_write(5'd0, 32'h0000_DEAD);

    //               v il alu a b res wr mr mw br j  rd  rs1 rs2 f3 imm           rs1d          rs2d
    add_vec("add",   32'h00008133, mk(1,0,4'd0,0,0,2'd0,1,0,0,0,0,5'd2, 5'd1, 5'd0, 3'd0,32'h0,        32'd5,        32'd0));
    add_vec("addi",  32'hFFF08193, mk(1,0,4'd0,0,1,2'd0,1,0,0,0,0,5'd3, 5'd1, 5'd31,3'd0,32'hFFFFFFFF, 32'd5,        32'd0));
    add_vec("sub",   32'h406283B3, mk(1,0,4'd1,0,0,2'd0,1,0,0,0,0,5'd7, 5'd5, 5'd6, 3'd0,32'h0,        32'h80000000, 32'd3));
    add_vec("sra",   32'h4062D433, mk(1,0,4'd7,0,0,2'd0,1,0,0,0,0,5'd8, 5'd5, 5'd6, 3'd5,32'h0,        32'h80000000, 32'd3));
    add_vec("srai",  32'h4042D493, mk(1,0,4'd7,0,1,2'd0,1,0,0,0,0,5'd9, 5'd5, 5'd4, 3'd5,32'h404,      32'h80000000, 32'd0));
    add_vec("lw",    32'hFFC0A503, mk(1,0,4'd0,0,1,2'd1,1,1,0,0,0,5'd10,5'd1, 5'd28,3'd2,32'hFFFFFFFC, 32'd5,        32'd0));
    add_vec("sw",    32'h0060A423, mk(1,0,4'd0,0,1,2'd0,0,0,1,0,0,5'd0, 5'd1, 5'd6, 3'd2,32'h8,        32'd5,        32'd3));
    add_vec("beq",   32'hFE608CE3, mk(1,0,4'd1,0,0,2'd0,0,0,0,1,0,5'd0, 5'd1, 5'd6, 3'd0,32'hFFFFFFF8, 32'd5,        32'd3));
    add_vec("jal",   32'hFFDFF0EF, mk(1,0,4'd0,1,1,2'd2,1,0,0,0,1,5'd1, 5'd31,5'd29,3'd7,32'hFFFFFFFC, 32'd0,        32'd0));
    add_vec("jalr",  32'h00008067, mk(1,0,4'd0,0,1,2'd2,1,0,0,0,1,5'd0, 5'd1, 5'd0, 3'd0,32'h0,        32'd5,        32'd0));
    add_vec("lui",   32'hABCDE5B7, mk(1,0,4'd10,0,1,2'd0,1,0,0,0,0,5'd11,5'd27,5'd28,3'd6,32'hABCDE000,32'd0,        32'd0));
    add_vec("auipc", 32'h00001617, mk(1,0,4'd0,1,1,2'd0,1,0,0,0,0,5'd12,5'd0, 5'd0, 3'd1,32'h1000,     32'd0,        32'd0));
    add_vec("illegal",32'hFFFFFFFF,mk(1,1,4'd0,0,0,2'd0,0,0,0,0,0,5'd0, 5'd31,5'd31,3'd7,32'h0,        32'd0,        32'd0));
    add_vec("x0_read",32'h000006B3,mk(1,0,4'd0,0,0,2'd0,1,0,0,0,0,5'd13,5'd0, 5'd0, 3'd0,32'h0,        32'd0,        32'd0));
    add_vec("bubble",32'h00000000, mk(0,0,4'd0,0,0,2'd0,0,0,0,0,0,5'd0, 5'd0, 5'd0, 3'd0,32'h0,        32'd0,        32'd0));
    foreach (vecs[i]) run_instr(vecs[i].name, vecs[i].instr, 5'(i), vecs[i].exp);

    // R-type sweep over funct3 with x5/x6 operands.
    for (int f = 0; f < 8; f++) begin
      rd = 5'($urandom_range(1, 31));
      pc = 5'($urandom_range(0, 31));
      e = mk(1,0,alu_tab[f],0,0,2'd0,1,0,0,0,0,rd,5'd5,5'd6,3'(f),32'h0,rf_model[5],rf_model[6]);
      run_instr("r_sweep", {7'b0, 5'd6, 5'd5, 3'(f), rd, 7'b0110011}, pc, e);
    end

    // I-ALU sweep over funct3 with random immediates (shift forms keep funct7=0).
    for (int f = 0; f < 8; f++) begin
      imm12 = 12'($urandom_range(0, 4095));
      if (f == 1 || f == 5) imm12[11:5] = 7'b0;
      rd = 5'($urandom_range(1, 31));
      pc = 5'($urandom_range(0, 31));
      e = mk(1,0,alu_tab[f],0,1,2'd0,1,0,0,0,0,rd,5'd6,imm12[4:0],3'(f),
             {{20{imm12[11]}}, imm12},rf_model[6],rf_model[imm12[4:0]]);
      run_instr("i_sweep", {imm12, 5'd6, 3'(f), rd, 7'b0010011}, pc, e);
    end

    // Same-edge writeback of x1 while loading add x2,x1,x0.
    i_WB_reg_wr_en = 1'b1; i_WB_rd_addr = 5'd1; i_WB_rd_data = 32'd7;
`ifdef ID_WB_BYPASS_EN
    e = mk(1,0,4'd0,0,0,2'd0,1,0,0,0,0,5'd2,5'd1,5'd0,3'd0,32'h0,32'd7,32'd0);
`else
    e = mk(1,0,4'd0,0,0,2'd0,1,0,0,0,0,5'd2,5'd1,5'd0,3'd0,32'h0,32'd5,32'd0);
`endif
    run_instr("wb_collision", 32'h00008133, 5'd2, e);
    i_WB_reg_wr_en = 1'b0;
    rf_model[1] = 32'd7;
    e = mk(1,0,4'd0,0,0,2'd0,1,0,0,0,0,5'd2,5'd1,5'd0,3'd0,32'h0,32'd7,32'd0);
    run_instr("wb_after", 32'h00008133, 5'd3, e);

    // Stall two cycles (new instruction and a WB write presented), then flush.
    held = mk(1,0,4'd1,0,0,2'd0,1,0,0,0,0,5'd7,5'd5,5'd6,3'd0,32'h0,32'h80000000,32'd3);
    run_instr("stall_load", 32'h406283B3, 5'd3, held);
    held.pc = 5'd3; held.pcn = 5'd7;
    i_stall = 1'b1;
    i_IF_instr = 32'hABCDE5B7; i_IF_program_cntr = 5'd9; i_IF_program_cntr_next = 5'd13;
    i_WB_reg_wr_en = 1'b1; i_WB_rd_addr = 5'd20; i_WB_rd_data = 32'h55;
    step("stall_hold1", held);
    i_WB_reg_wr_en = 1'b0;
    rf_model[20] = 32'h55;
    step("stall_hold2", held);
    i_flush = 1'b1;
    step("flush", '0);
    i_flush = 1'b0; i_stall = 1'b0;
    e = mk(1,0,4'd0,0,0,2'd0,1,0,0,0,0,5'd21,5'd20,5'd0,3'd0,32'h0,32'h55,32'd0);
    run_instr("wb_during_stall", 32'h000A0AB3, 5'd4, e);

    // Asynchronous reset mid-cycle, then confirm the register file was cleared.
    e = mk(1,0,4'd10,0,1,2'd0,1,0,0,0,0,5'd11,5'd27,5'd28,3'd6,32'hABCDE000,32'd0,32'd0);
    run_instr("pre_reset", 32'hABCDE5B7, 5'd5, e);
    #3;
    i_reset_n = 1'b0;
    exp_q.push_back('0);
    #1 check_out("async_reset");
    step("reset_hold2", '0);
    i_reset_n = 1'b1;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    e = mk(1,0,4'd0,0,0,2'd0,1,0,0,0,0,5'd2,5'd1,5'd0,3'd0,32'h0,rf_model[1],32'd0);
    run_instr("rf_cleared", 32'h00008133, 5'd6, e);

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover: %0d expected entries not consumed", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
